multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: WAIT_LIMIT, default 15, max cycles in a memory state before timeout (1..255).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 op  input  6  opcode, bits [31:26] of the instruction register.
REQ-005 mem_ready  input  1  memory completes current access this cycle.
REQ-006 mem_req  output  1  memory access requested.
REQ-007 MemRead, MemWrite  output  1 each  memory access direction.
REQ-008 IorD  output  1  memory address source: 0 = PC, 1 = ALUOut.
REQ-009 IRWrite  output  1  load instruction register.
REQ-010 PCWrite, PCWriteCond  output  1 each  unconditional / branch-qualified PC load.
REQ-011 RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  datapath selects and register-file write enable.
REQ-012 ALUSrcB  output  2  ALU B source: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
REQ-013 ULAOp  output  2  to ALU decoder: 00 = add, 01 = sub (beq), 10 = use funct, 11 = sub (bne).
REQ-014 PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-015 illegal_op, bus_error  output  1 each  one-cycle error pulses.

Function
REQ-016 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP.
REQ-017 Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
REQ-018 FETCH: mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ULAOp=00, PCSource=00.
REQ-019 FETCH: IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; on that cycle the FSM goes to DECODE, otherwise it stays in FETCH.
REQ-020 DECODE: ALUSrcA=0, ALUSrcB=11, ULAOp=00.
REQ-021 DECODE next state: lw/sw -> MEMADR; R -> EXEC; addi -> ADDIEX; beq/bne -> BRANCH; j -> JUMP.
REQ-022 DECODE with any other opcode: next state FETCH and illegal_op pulses for exactly that one cycle.
REQ-023 MEMADR: ALUSrcA=1, ALUSrcB=10, ULAOp=00; next state MEMRD for lw, MEMWR for sw.
REQ-024 MEMRD: mem_req=1, MemRead=1, IorD=1; advances to MEMWB on mem_ready.
REQ-025 MEMWR: mem_req=1, MemWrite=1, IorD=1; advances to FETCH on mem_ready.
REQ-026 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
REQ-027 EXEC: ALUSrcA=1, ALUSrcB=00, ULAOp=10; then ALUWB.
REQ-028 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; then FETCH.
REQ-029 ADDIEX: ALUSrcA=1, ALUSrcB=10, ULAOp=00; then ADDIWB.
REQ-030 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; then FETCH.
REQ-031 BRANCH: ALUSrcA=1, ALUSrcB=00, PCWriteCond=1, PCSource=01, ULAOp=01 for beq / 11 for bne; then FETCH.
REQ-032 JUMP: PCWrite=1, PCSource=10; then FETCH.
REQ-033 Any output not listed for a state SHALL be 0.
REQ-034 An 8-bit wait counter SHALL clear on entry to FETCH, MEMRD and MEMWR and increment each cycle spent waiting in them.
REQ-035 If the counter reaches WAIT_LIMIT without mem_ready: bus_error pulses one cycle, the FSM goes to FETCH, and no IRWrite, PCWrite or RegWrite occurs.
REQ-036 mem_ready together with the timeout in the same cycle: mem_ready wins, no bus_error.
REQ-037 mem_ready outside the memory states SHALL be ignored.
REQ-038 Outputs SHALL depend only on state and the wait counter, except the IRWrite/PCWrite gating in FETCH.

Reset
REQ-039 While rst=1 at a clock edge: next state FETCH, wait counter 0.
REQ-040 While rst=1, every output SHALL be forced to 0, including IRWrite and PCWrite regardless of mem_ready.
REQ-041 Reset asserted mid-access (MEMRD or MEMWR) SHALL abandon the access; no RegWrite follows.

Structure
REQ-042 A shared package SHALL hold the state enum, the opcode constants, and the ULAOp, ALUSrcB and PCSource encodings.
REQ-043 The block SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-044 R-type add, op=000000, mem_ready=1 in FETCH -> states FETCH, DECODE, EXEC, ALUWB; ULAOp=10 in EXEC; RegWrite=1, RegDst=1 in ALUWB; 4 cycles total.
REQ-045 lw with mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with RegWrite=1, MemtoReg=1; 5+3 cycles total.
REQ-046 beq, then bne -> BRANCH shows PCWriteCond=1, PCSource=01 with ULAOp=01, then ULAOp=11.
REQ-047 op=111111 -> illegal_op high exactly 1 cycle in DECODE; next state FETCH; no write strobes.
REQ-048 WAIT_LIMIT=4, mem_ready held 0 in MEMWR -> bus_error pulse after 4 wait cycles, then FETCH; MemWrite deasserts.
REQ-049 rst=1 asserted in MEMRD with mem_ready=1 -> all outputs 0 that cycle; FETCH next; no RegWrite.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes and
// the select-field encodings driven onto the datapath.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ULAOP_ADD   = 2'b00;
    localparam logic [1:0] ULAOP_BEQ   = 2'b01;
    localparam logic [1:0] ULAOP_FUNCT = 2'b10;
    localparam logic [1:0] ULAOP_BNE   = 2'b11;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FETCH doubles as the "unsupported opcode" marker for DECODE.
    function automatic state_e decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:    return MEMADR;
            OP_R:            return EXEC;
            OP_ADDI:         return ADDIEX;
            OP_BEQ, OP_BNE:  return BRANCH;
            OP_J:            return JUMP;
            default:         return FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with a memory-wait watchdog; strobes decode from
// the current state, only the FETCH load strobes follow mem_ready directly.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ULAOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic       bus_error
);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       bne_q, bne_d;
    logic       bus_err_q, bus_err_d;
    logic       mem_state;
    logic       timeout;

    always_comb begin
        mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
        // Expires on the WAIT_LIMIT-th cycle spent in the state; a ready that
        // same cycle still wins.
        timeout   = mem_state && !mem_ready && (({1'b0, wait_q} + 9'd1) == 9'(WAIT_LIMIT));
        state_d   = state_q;
        bne_d     = bne_q;
        bus_err_d = 1'b0;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                state_d = decode_next(op);
                bne_d   = (op == OP_BNE);
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWR:   if (mem_ready) state_d = FETCH;
            EXEC:    state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
        if (timeout) begin
            state_d   = FETCH;
            bus_err_d = 1'b1;
        end
        wait_d = ((state_d != state_q) || timeout) ? 8'd0 : wait_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_q    <= 8'd0;
            bne_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bne_q     <= bne_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ULAOp       = ULAOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        bus_error   = 1'b0;
        if (!rst) begin
            bus_error = bus_err_q;
            case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB    = SRCB_IMMSH;
                    illegal_op = (decode_next(op) == FETCH);
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWR: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_REG;
                    ULAOp   = ULAOP_FUNCT;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                ADDIWB:  RegWrite = 1'b1;
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                    ULAOp       = bne_q ? ULAOP_BNE : ULAOP_BEQ;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected
// per-cycle strobe sequence and mem_ready schedule, then replayed on the DUT.
module tb_multicycle_control;

    localparam int WL = 4;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101;
    localparam logic [5:0] T_ADDI = 6'b001000, T_J = 6'b000010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b0;
    logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, illegal_op, bus_error;
    logic [1:0] ALUSrcB, ULAOp, PCSource;

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ULAOp(ULAOp), .PCSource(PCSource),
        .illegal_op(illegal_op), .bus_error(bus_error)
    );

    typedef struct packed {
        logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
        logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
        logic [1:0] ALUSrcB, ULAOp, PCSource;
        logic       illegal_op, bus_error;
    } outv_t;

    outv_t act;
    assign act = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
                  RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ULAOp, PCSource,
                  illegal_op, bus_error};

    outv_t      exp_q[$];
    bit         rdy_q[$];
    bit         rst_q[$];
    logic [5:0] op_q[$];
    bit         pend = 1'b0;
    bit         cur_rst = 1'b0;
    logic [5:0] cur_op = 6'd0;
    int         n_vec = 0;
    int         n_bad = 0;

    function automatic bit legal(input logic [5:0] o);
        return o inside {T_R, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_J};
    endfunction

    function automatic outv_t v_fetch(input bit done);
        outv_t v = '0;
        v.mem_req = 1; v.MemRead = 1; v.ALUSrcB = 2'b01;
        v.IRWrite = done; v.PCWrite = done;
        return v;
    endfunction

    function automatic outv_t v_decode(input bit ill);
        outv_t v = '0;
        v.ALUSrcB = 2'b11; v.illegal_op = ill;
        return v;
    endfunction

    function automatic outv_t v_alu_imm();
        outv_t v = '0;
        v.ALUSrcA = 1; v.ALUSrcB = 2'b10;
        return v;
    endfunction

    function automatic outv_t v_mem(input bit wr);
        outv_t v = '0;
        v.mem_req = 1; v.IorD = 1; v.MemRead = !wr; v.MemWrite = wr;
        return v;
    endfunction

    task automatic push(input outv_t v, input bit r);
        if (pend && !cur_rst) v.bus_error = 1'b1;
        pend = 1'b0;
        exp_q.push_back(v);
        rdy_q.push_back(r);
        rst_q.push_back(cur_rst);
        op_q.push_back(cur_op);
    endtask

    task automatic push_any(input outv_t v);
        push(v, 1'($urandom % 2));
    endtask

    // Memory access ready after d idle cycles, or watchdog expiry after WL idle cycles.
    task automatic mem_phase(input outv_t base, input outv_t done_v, input int d, output bit ok);
        if (d < WL) begin
            for (int i = 0; i < d; i++) push(base, 1'b0);
            push(done_v, 1'b1);
            ok = 1'b1;
        end else begin
            for (int i = 0; i < WL; i++) push(base, 1'b0);
            pend = 1'b1;
            ok = 1'b0;
        end
    endtask

    task automatic gen_instr(input logic [5:0] o, input int fd, input int md);
        outv_t v;
        bit ok;
        cur_op = o;
        mem_phase(v_fetch(1'b0), v_fetch(1'b1), fd, ok);
        if (!ok) return;
        push_any(v_decode(!legal(o)));
        if (!legal(o)) return;
        case (o)
            T_LW, T_SW: begin
                push_any(v_alu_imm());
                mem_phase(v_mem(o == T_SW), v_mem(o == T_SW), md, ok);
                if (ok && o == T_LW) begin
                    v = '0; v.RegWrite = 1; v.MemtoReg = 1;
                    push_any(v);
                end
            end
            T_R: begin
                v = '0; v.ALUSrcA = 1; v.ULAOp = 2'b10;
                push_any(v);
                v = '0; v.RegWrite = 1; v.RegDst = 1;
                push_any(v);
            end
            T_ADDI: begin
                push_any(v_alu_imm());
                v = '0; v.RegWrite = 1;
                push_any(v);
            end
            T_BEQ, T_BNE: begin
                v = '0; v.ALUSrcA = 1; v.PCWriteCond = 1; v.PCSource = 2'b01;
                v.ULAOp = (o == T_BNE) ? 2'b11 : 2'b01;
                push_any(v);
            end
            default: begin
                v = '0; v.PCWrite = 1; v.PCSource = 2'b10;
                push_any(v);
            end
        endcase
    endtask

    task automatic flush(input string name);
        outv_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            rst = rst_q.pop_front();
            op = op_q.pop_front();
            @(negedge clk);
            n_vec++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s vec%0d: got %b want %b", name, n_vec, act, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        cur_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cur_op = 6'($urandom);
            push('0, 1'b1);
        end
        cur_rst = 1'b0;
        gen_instr(T_R, 1, 0);
        flush("reset");
    endtask

    task automatic test_rtype();
        gen_instr(T_R, 0, 0);
        gen_instr(T_ADDI, 2, 0);
        flush("rtype_addi");
    endtask

    task automatic test_lw_delay();
        gen_instr(T_LW, 0, 3);
        gen_instr(T_SW, 1, 2);
        flush("lw_sw");
    endtask

    task automatic test_branch();
        gen_instr(T_BEQ, 0, 0);
        gen_instr(T_BNE, 0, 0);
        gen_instr(T_J, 0, 0);
        flush("branch_jump");
    endtask

    task automatic test_illegal();
        logic [5:0] o;
        gen_instr(6'b111111, 0, 0);
        do o = 6'($urandom); while (legal(o));
        gen_instr(o, 1, 0);
        gen_instr(T_R, 0, 0);
        flush("illegal");
    endtask

    task automatic test_bus_error();
        gen_instr(T_SW, 0, WL + 2);
        gen_instr(T_ADDI, 0, 0);
        gen_instr(T_LW, 0, WL);
        gen_instr(T_J, WL, 0);
        gen_instr(T_R, 2, 0);
        flush("bus_error");
    endtask

    task automatic test_reset_midaccess();
        cur_op = T_LW;
        push(v_fetch(1'b1), 1'b1);
        push_any(v_decode(1'b0));
        push_any(v_alu_imm());
        push(v_mem(1'b0), 1'b0);
        push(v_mem(1'b0), 1'b0);
        cur_rst = 1'b1;
        push('0, 1'b1);
        cur_rst = 1'b0;
        gen_instr(T_R, 1, 0);
        flush("rst_midaccess");
    endtask

    task automatic test_random();
        logic [5:0] o;
        int fd, md;
        for (int n = 0; n < 150; n++) begin
            case ($urandom % 8)
                0: o = T_R;    1: o = T_LW;  2: o = T_SW;  3: o = T_BEQ;
                4: o = T_BNE;  5: o = T_ADDI; 6: o = T_J;
                default: o = 6'($urandom);
            endcase
            fd = ($urandom % 4 == 0) ? int'($urandom_range(0, WL + 1)) : int'($urandom_range(0, 1));
            md = ($urandom % 3 == 0) ? int'($urandom_range(0, WL + 1)) : int'($urandom_range(0, 2));
            gen_instr(o, fd, md);
            flush("random");
        end
        gen_instr(T_R, 0, 0);
        flush("random_tail");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_lw_delay();
        test_branch();
        test_illegal();
        test_bus_error();
        test_reset_midaccess();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
